// File: rtl/crash_detect_if.sv
// crash_detect_if: carries ball/paddle positions into the collision block and
// the crash vector and scoring state back out.
`default_nettype none

interface crash_detect_if;
  logic [9:0] iBall_x;
  logic [9:0] iBall_y;
  logic [9:0] iPaddleL_y;
  logic [9:0] iPaddleR_y;
  logic [3:0] oCrash;
  logic [3:0] oScoreL;
  logic [3:0] oScoreR;
  logic       oMiss;
  logic       oGame_over;

  modport master (
    output iBall_x, iBall_y, iPaddleL_y, iPaddleR_y,
    input  oCrash, oScoreL, oScoreR, oMiss, oGame_over
  );

  modport slave (
    input  iBall_x, iBall_y, iPaddleL_y, iPaddleR_y,
    output oCrash, oScoreL, oScoreR, oMiss, oGame_over
  );
endinterface

`default_nettype wire

// File: rtl/crash_detect.sv
// ============================================================================
// crash_detect: per-frame wall/paddle collision flags, miss scoring, game over.
// Optional scoring logic is built only when CRASH_SCORE_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crash_detect #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SCORE_MAX      = 9
) (
  input  logic           iFrame_CLK,
  input  logic           iRST_n,
  crash_detect_if.slave  bus
);

  localparam logic [10:0] c_BALL     = 11'(BALL_SIZE);
  localparam logic [10:0] c_PAD_H    = 11'(PADDLE_H);
  localparam logic [10:0] c_MARGIN   = 11'd4;
  localparam logic [10:0] c_LPAD_LO  = 11'(LEFT_PADDLE_X);
  localparam logic [10:0] c_LPAD_HI  = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] c_RPAD_LO  = 11'(RIGHT_PADDLE_X);
  localparam logic [10:0] c_RPAD_HI  = 11'(RIGHT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] c_RWALL    = 11'(SCREEN_W - 4);
  localparam logic [10:0] c_DWALL    = 11'(SCREEN_H - 4);
  localparam logic [9:0]  c_UNDERFLOW = 10'd960;

  if (SCORE_MAX < 1 || SCORE_MAX > 15) begin : g_score_max_check
    $error("crash_detect: SCORE_MAX must be in 1..15");
  end

  // Positions at or above 960 are a ball that stepped just past zero.
  logic [10:0] w_x, w_y, w_pl, w_pr;
  assign w_x  = (bus.iBall_x >= c_UNDERFLOW) ? 11'd0 : {1'b0, bus.iBall_x};
  assign w_y  = (bus.iBall_y >= c_UNDERFLOW) ? 11'd0 : {1'b0, bus.iBall_y};
  assign w_pl = {1'b0, bus.iPaddleL_y};
  assign w_pr = {1'b0, bus.iPaddleR_y};

  logic w_ovl_l, w_ovl_r, w_wall_l, w_wall_r, w_face_l, w_face_r;
  logic w_left, w_right, w_up, w_down;
  assign w_ovl_l  = (w_y + c_BALL > w_pl) && (w_y < w_pl + c_PAD_H);
  assign w_ovl_r  = (w_y + c_BALL > w_pr) && (w_y < w_pr + c_PAD_H);
  assign w_wall_l = (w_x <= c_MARGIN);
  assign w_wall_r = (w_x + c_BALL >= c_RWALL);
  assign w_face_l = (w_x >= c_LPAD_LO) && (w_x <= c_LPAD_HI) && w_ovl_l;
  assign w_face_r = (w_x + c_BALL >= c_RPAD_LO) && (w_x + c_BALL <= c_RPAD_HI) && w_ovl_r;
  assign w_left   = w_wall_l || w_face_l;
  assign w_right  = w_wall_r || w_face_r;
  assign w_up     = (w_y <= c_MARGIN);
  assign w_down   = (w_y + c_BALL >= c_DWALL);

  logic [3:0] r_crash;
  always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
    if (!iRST_n) r_crash <= 4'b0000;
    else         r_crash <= {w_left, w_right, w_up, w_down};
  end
  assign bus.oCrash = r_crash;

`ifdef CRASH_SCORE_EN
  localparam logic [3:0]  c_SMAX    = 4'(SCORE_MAX);
  localparam logic [10:0] c_MID_LO  = 11'(SCREEN_W / 4);
  localparam logic [10:0] c_MID_HI  = 11'(3 * SCREEN_W / 4);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    LOCKOUT = 2'd1,
    OVER    = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_score_l, r_score_r;
  logic       r_miss, r_game_over;
  logic       w_miss_l, w_miss_r, w_centre;

  assign w_miss_l = w_wall_l && !w_ovl_l;
  assign w_miss_r = w_wall_r && !w_ovl_r;
  assign w_centre = (w_x >= c_MID_LO) && (w_x < c_MID_HI);

  // Left-wall miss wins if both sides report a miss on the same frame.
  always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= PLAY;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        PLAY: begin
          if (w_miss_l) begin
            r_miss <= 1'b1;
            if (r_score_r < c_SMAX) r_score_r <= r_score_r + 4'd1;
            if (r_score_r + 4'd1 >= c_SMAX) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state <= LOCKOUT;
            end
          end else if (w_miss_r) begin
            r_miss <= 1'b1;
            if (r_score_l < c_SMAX) r_score_l <= r_score_l + 4'd1;
            if (r_score_l + 4'd1 >= c_SMAX) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state <= LOCKOUT;
            end
          end
        end
        LOCKOUT: begin
          if (w_centre) r_state <= PLAY;
        end
        OVER: begin
          r_game_over <= 1'b1;
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign bus.oScoreL    = r_score_l;
  assign bus.oScoreR    = r_score_r;
  assign bus.oMiss      = r_miss;
  assign bus.oGame_over = r_game_over;
`else
  assign bus.oScoreL    = 4'd0;
  assign bus.oScoreR    = 4'd0;
  assign bus.oMiss      = 1'b0;
  assign bus.oGame_over = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crash_detect.sv
// tb_crash_detect: scoreboard bench for crash_detect; expected scoring outputs
// collapse to zero when CRASH_SCORE_EN is not defined.
`default_nettype none

module tb_crash_detect;

  logic iFrame_CLK = 1'b0;
  logic iRST_n;

  crash_detect_if bus ();

  crash_detect dut (
    .iFrame_CLK (iFrame_CLK),
    .iRST_n     (iRST_n),
    .bus        (bus.slave)
  );

  always #5 iFrame_CLK = ~iFrame_CLK;

`ifdef CRASH_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [13:0] sb[$];

  // Packs {crash, scoreL, scoreR, miss, game_over}.
  function automatic logic [13:0] expv(input logic [3:0] c, input int sl, input int sr,
                                       input logic m, input logic g);
    if (SCORE_EN) return {c, 4'(sl), 4'(sr), m, g};
    return {c, 10'd0};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.oCrash, bus.oScoreL, bus.oScoreR, bus.oMiss, bus.oGame_over};
  endfunction

  task automatic apply(input int x, input int y, input int pl, input int pr,
                       input logic [13:0] e);
    bus.iBall_x    = 10'(x);
    bus.iBall_y    = 10'(y);
    bus.iPaddleL_y = 10'(pl);
    bus.iPaddleR_y = 10'(pr);
    sb.push_back(e);
    @(posedge iFrame_CLK);
    #1;
  endtask

  task automatic pulse_reset();
    iRST_n = 1'b0;
    #2;
    iRST_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] e, o;
    iRST_n = 1'b1;
    bus.iBall_x = 10'd4; bus.iBall_y = 10'd300;
    bus.iPaddleL_y = 10'd0; bus.iPaddleR_y = 10'd0;
    repeat (2) @(posedge iFrame_CLK);
    #3;
    iRST_n = 1'b0;
    sb.push_back(expv(4'b0000, 0, 0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_async: got %b want %b", o, e); end
    bus.iBall_x = 10'd320; bus.iBall_y = 10'd240;
    @(posedge iFrame_CLK); #1;
    iRST_n = 1'b1;
    apply(320, 240, 200, 200, expv(4'b0000, 0, 0, 1'b0, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_first_edge: got %b want %b", o, e); end
  endtask

  task automatic test_paddle_faces();
    logic [13:0] e, o;
    int xs[7]        = '{24, 16, 25, 608, 616, 617, 320};
    logic [3:0] c[7] = '{4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      apply(xs[i], 220, 200, 200, expv(c[i], 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL paddle_face x=%0d: got %b want %b", xs[i], o, e); end
    end
  endtask

  task automatic test_wall_bounds();
    logic [13:0] e, o;
    int xs[8]        = '{5, 4, 627, 628, 320, 320, 320, 320};
    int ys[8]        = '{220, 220, 220, 220, 4, 5, 468, 467};
    logic [3:0] c[8] = '{4'b0000, 4'b1000, 4'b0000, 4'b0100,
                         4'b0010, 4'b0000, 4'b0001, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      apply(xs[i], ys[i], 200, 200, expv(c[i], 0, 0, 1'b0, 1'b0));
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL wall_bound x=%0d y=%0d: got %b want %b", xs[i], ys[i], o, e); end
    end
  endtask

  task automatic test_left_miss();
    logic [13:0] e, o;
    apply(4, 300, 0, 0, expv(4'b1000, 0, 1, 1'b1, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL left_miss: got %b want %b", o, e); end
    for (int i = 0; i < 3; i++) begin
      apply(4, 300, 0, 0, expv(4'b1000, 0, 1, 1'b0, 1'b0));
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL lockout_hold %0d: got %b want %b", i, o, e); end
    end
    apply(320, 300, 0, 0, expv(4'b0000, 0, 1, 1'b0, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL lockout_exit: got %b want %b", o, e); end
  endtask

  task automatic test_corner();
    logic [13:0] e, o;
    apply(628, 468, 0, 0, expv(4'b0101, 1, 1, 1'b1, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL corner: got %b want %b", o, e); end
    apply(320, 240, 0, 0, expv(4'b0000, 1, 1, 1'b0, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL corner_return: got %b want %b", o, e); end
  endtask

  task automatic test_game_over();
    logic [13:0] e, o;
    bus.iBall_x = 10'd320;
    pulse_reset();
    for (int k = 1; k <= 9; k++) begin
      apply(632, 240, 0, 0, expv(4'b0100, k, 0, 1'b1, k == 9));
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL game_miss %0d: got %b want %b", k, o, e); end
      apply(320, 240, 0, 0, expv(4'b0000, k, 0, 1'b0, k == 9));
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL game_return %0d: got %b want %b", k, o, e); end
    end
    apply(632, 240, 0, 0, expv(4'b0100, 9, 0, 1'b0, 1'b1));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL game_frozen: got %b want %b", o, e); end
  endtask

  task automatic test_underflow();
    logic [13:0] e, o;
    bus.iBall_x = 10'd320;
    pulse_reset();
    apply(1022, 100, 0, 0, expv(4'b1000, 0, 1, 1'b1, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL underflow_x: got %b want %b", o, e); end
    apply(320, 1000, 0, 0, expv(4'b0010, 0, 1, 1'b0, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL underflow_y: got %b want %b", o, e); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e, o;
    apply(628, 100, 0, 0, expv(4'b0100, 1, 1, 1'b1, 1'b0));
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL pre_reset_miss: got %b want %b", o, e); end
    #3;
    iRST_n = 1'b0;
    sb.push_back(expv(4'b0000, 0, 0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_mid: got %b want %b", o, e); end
    iRST_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_paddle_faces();
    test_wall_bounds();
    test_left_miss();
    test_corner();
    test_game_over();
    test_underflow();
    test_reset_mid();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
